// File: rtl/sram_access_sequencer.sv
// ============================================================================
// sram_access_sequencer
//   Timed SETUP/ACCESS/RECOVER wordline/bitline sequencer for one SRAM cell.
//   Optional write-verify compare built only when SRAM_WR_VERIFY_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_access_sequencer #(
    parameter int  SETUP_CYC   = 2,
    parameter int  ACCESS_CYC  = 3,
    parameter int  RECOVER_CYC = 1,
    parameter real VDD_V       = 1.5,
    parameter real VSS_V       = 0.0,
    parameter real VSENSE_V    = 0.75
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_we,
    input  logic req_wdata,
    output real  wl_v,
    output real  bl_v,
    input  real  cell_v,
    output logic rsp_valid,
    output logic rsp_rdata,
    output logic busy,
    output logic wr_err
);

    localparam int MAX_SA  = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
    localparam int MAX_CYC = (MAX_SA > RECOVER_CYC) ? MAX_SA : RECOVER_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] C_SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] C_ACCESS_LD  = CNT_W'(ACCESS_CYC - 1);
    localparam logic [CNT_W-1:0] C_RECOVER_LD = CNT_W'(RECOVER_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_ACCESS  = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_wl, w_wl_nxt;
    logic             r_bl, w_bl_nxt;
    logic             r_rdy, w_rdy_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_rsp_v, w_rsp_v_nxt;
    logic             r_rdata, w_rdata_nxt;
    logic             w_accept;
    logic             w_sample;
    logic             w_sense;

    assign w_accept = req_valid && r_rdy;
    assign w_sample = (r_state == S_ACCESS) && (r_cnt == '0);
    assign w_sense  = (cell_v >= VSENSE_V);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wl_nxt    = r_wl;
        w_bl_nxt    = r_bl;
        w_rsp_v_nxt = 1'b0;
        w_rdata_nxt = r_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = C_SETUP_LD;
                    w_wl_nxt    = 1'b0;
                    // Reads release the bitline; writes drive the data level.
                    w_bl_nxt    = req_we & req_wdata;
                end
            end
            S_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_ACCESS;
                    w_cnt_nxt   = C_ACCESS_LD;
                    w_wl_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_ACCESS: begin
                if (w_sample) begin
                    w_state_nxt = S_RECOVER;
                    w_cnt_nxt   = C_RECOVER_LD;
                    w_wl_nxt    = 1'b0;
                    w_bl_nxt    = 1'b0;
                    w_rsp_v_nxt = 1'b1;
                    w_rdata_nxt = w_sense;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_RECOVER: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_wl_nxt    = 1'b0;
                w_bl_nxt    = 1'b0;
            end
        endcase
        w_rdy_nxt  = (w_state_nxt == S_IDLE);
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wl    <= 1'b0;
            r_bl    <= 1'b0;
            r_rdy   <= 1'b1;
            r_busy  <= 1'b0;
            r_rsp_v <= 1'b0;
            r_rdata <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wl    <= w_wl_nxt;
            r_bl    <= w_bl_nxt;
            r_rdy   <= w_rdy_nxt;
            r_busy  <= w_busy_nxt;
            r_rsp_v <= w_rsp_v_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    // Voltage levels are a pure decode of registered bits, so the async
    // reset drops the wordline without waiting for a clock edge.
    assign wl_v      = r_wl ? VDD_V : VSS_V;
    assign bl_v      = r_bl ? VDD_V : VSS_V;
    assign req_ready = r_rdy;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_v;
    assign rsp_rdata = r_rdata;

`ifdef SRAM_WR_VERIFY_EN
    logic r_we;
    logic r_wdata;
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_wdata <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_wdata <= req_wdata;
            if (req_we) begin
                r_err <= 1'b0;
            end
        end else if (w_sample && r_we) begin
            r_err <= (w_sense != r_wdata);
        end
    end

    assign wr_err = r_err;
`else
    assign wr_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_access_sequencer.sv
// ============================================================================
// tb_sram_access_sequencer
//   Randomized scoreboard bench with a behavioural cell and reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_access_sequencer #(
    parameter int SETUP_CYC   = 2,
    parameter int ACCESS_CYC  = 3,
    parameter int RECOVER_CYC = 1
);

    localparam int  TOT      = SETUP_CYC + ACCESS_CYC + RECOVER_CYC;
    localparam real VTH      = 0.4;
    localparam real VSENSE   = 0.75;
`ifdef SRAM_WR_VERIFY_EN
    localparam bit  VERIFY   = 1'b1;
`else
    localparam bit  VERIFY   = 1'b0;
`endif

    typedef struct {
        int due;
        bit rd;
        bit err;
    } exp_t;

    logic clk;
    logic rst_n;
    logic req_valid;
    logic req_ready;
    logic req_we;
    logic req_wdata;
    real  wl_v;
    real  bl_v;
    real  cell_v = 0.0;
    logic rsp_valid;
    logic rsp_rdata;
    logic busy;
    logic wr_err;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   last_a = -1000;
    real  m_cell = 0.0;
    bit   m_err  = 1'b0;
    bit   rand_mode = 1'b0;
    exp_t q[$];

    bit   leak_tgl  = 1'b0;
    bit   leak_seen = 1'b0;
    real  leak_val  = 0.0;

    sram_access_sequencer #(
        .SETUP_CYC  (SETUP_CYC),
        .ACCESS_CYC (ACCESS_CYC),
        .RECOVER_CYC(RECOVER_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_wdata(req_wdata),
        .wl_v     (wl_v),
        .bl_v     (bl_v),
        .cell_v   (cell_v),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .busy     (busy),
        .wr_err   (wr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Access-transistor cell: charges to the bitline only when both the gate
    // and drain are above threshold, otherwise holds its charge.
    always @(wl_v or bl_v or leak_tgl) begin
        if (leak_tgl != leak_seen) begin
            cell_v    = leak_val;
            leak_seen = leak_tgl;
        end
        if (wl_v > VTH && bl_v > VTH) cell_v = bl_v;
    end

    function automatic int mv(input real v);
        return $rtoi(v * 1000.0 + 0.5);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One negedge-aligned cycle: check readiness, optionally disturb an idle
    // cell, drive the request, and predict its outcome when accepted.
    task automatic step(input bit v, input bit we, input bit wd, output bit acc);
        bit   rdy;
        bit   rd;
        exp_t e;
        real  lv[6];
        lv = '{0.0, 0.5, 0.749, 0.75, 1.0, 1.5};
        @(negedge clk);
        rdy = (cyc >= last_a + TOT);
        chk("req_ready", int'(req_ready), int'(rdy));
        chk("busy", int'(busy), int'(!rdy));
        if (rand_mode && rdy && $urandom_range(0, 3) == 0) begin
            leak_val = lv[$urandom_range(0, 5)];
            m_cell   = leak_val;
            leak_tgl = ~leak_tgl;
        end
        req_valid = v;
        req_we    = we;
        req_wdata = wd;
        acc = v && rdy;
        if (acc) begin
            last_a = cyc + 1;
            rd = (we && wd) ? 1'b1 : (m_cell >= VSENSE);
            if (we && wd) m_cell = 1.5;
            if (VERIFY && we) m_err = (rd != wd);
            e.due = last_a + SETUP_CYC + ACCESS_CYC;
            e.rd  = rd;
            e.err = m_err;
            q.push_back(e);
        end
    endtask

    task automatic txn(input bit we, input bit wd);
        bit acc;
        int n;
        int a;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 2 * TOT + 4) begin
            step(1'b1, we, wd, acc);
            n = n + 1;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        a = last_a;
        while (cyc < a + TOT) begin
            step(1'b0, 1'b0, 1'b0, acc);
            if (cyc == a + SETUP_CYC) begin
                chk("wl_access", mv(wl_v), 1500);
                chk("bl_access", mv(bl_v), (we && wd) ? 1500 : 0);
                chk("cell_access", mv(cell_v), mv(m_cell));
            end
        end
    endtask

    task automatic reset_mid_access();
        bit acc;
        int a;
        txn_accept_only();
        a = last_a;
        while (cyc < a + SETUP_CYC - 1) step(1'b0, 1'b0, 1'b0, acc);
        @(posedge clk);
        #1;
        chk("wl_before_rst", mv(wl_v), 1500);
        rst_n = 1'b0;
        #1;
        chk("wl_async_rst", mv(wl_v), 0);
        chk("ready_in_rst", int'(req_ready), 1);
        chk("busy_in_rst", int'(busy), 0);
        q.delete();
        last_a = -1000;
        m_err  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic txn_accept_only();
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 2 * TOT + 4) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
            n = n + 1;
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    // Scoreboard monitor: responses and output-level invariants.
    int prev_wl = 0;
    int prev_bl = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (!(mv(wl_v) inside {0, 1500})) chk("wl_level", mv(wl_v), 1500);
            if (!(mv(bl_v) inside {0, 1500})) chk("bl_level", mv(bl_v), 1500);
            if (mv(wl_v) == 1500 && prev_wl == 0) chk("bl_stable_at_wl_rise", mv(bl_v), prev_bl);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_cycle", cyc, e.due);
                    chk("rsp_rdata", int'(rsp_rdata), int'(e.rd));
                    chk("wr_err", int'(wr_err), int'(e.err));
                end
            end else if (q.size() != 0 && cyc > q[0].due) begin
                chk("rsp_missing", 0, 1);
                e = q.pop_front();
            end
        end
        prev_wl = mv(wl_v);
        prev_bl = mv(bl_v);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wdata = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_rdata", int'(rsp_rdata), 0);
        chk("rst_wr_err", int'(wr_err), 0);
        chk("rst_wl", mv(wl_v), 0);
        chk("rst_bl", mv(bl_v), 0);
        rst_n = 1'b1;

        txn(1'b1, 1'b1);
        txn(1'b0, 1'b0);
        txn(1'b1, 1'b0);
        txn(1'b0, 1'b0);
        txn(1'b1, 1'b1);

        for (int i = 0; i < 2 * TOT + 3; i++) step(1'b1, 1'b1, 1'b1, acc);
        for (int i = 0; i < TOT + 2; i++) step(1'b0, 1'b0, 1'b0, acc);

        reset_mid_access();
        for (int i = 0; i < TOT + 2; i++) step(1'b0, 1'b0, 1'b0, acc);

        rand_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), acc);
        end
        rand_mode = 1'b0;
        for (int i = 0; i < TOT + 4; i++) step(1'b0, 1'b0, 1'b0, acc);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
